// File: rtl/bcd2bin_ctrl.sv
// bcd2bin_ctrl: control and digit-correction stage of the 5-digit BCD-to-binary
// converter. Sequences the external rsr4 shift register through a load followed
// by ITER shift/correct pairs, and builds the binary result from the bits that
// drop out of digit 0 (reverse double-dabble).
module bcd2bin_ctrl #(
    parameter int ITER = 16,
    parameter int NDIG = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic                busy,
    output logic                done,
    output logic [ITER-1:0]     bin_out,
    output logic                ovf,
    output logic                bad_digit,
    output logic                rst_ld,
    output logic                shift,
    output logic [NDIG-1:0]     lda2,
    output logic [4*NDIG-1:0]   in_R1,
    output logic [4*NDIG-1:0]   in_R2,
    input  logic [4*NDIG-1:0]   out_R
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CORR,
        DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [ITER-1:0] acc;
    logic            nib_bad;

    // Flag any operand nibble outside 0..9.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        nib_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                nib_bad = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = nib_bad ? DONE : LOAD;
            LOAD:    state_n = SHIFT;
            SHIFT:   state_n = CORR;
            CORR:    state_n = (cnt == CNT_LAST) ? DONE : SHIFT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control outputs decoded from state; corrections decoded from the rsr4 window.
    always_comb begin
        busy   = (state == LOAD) || (state == SHIFT) || (state == CORR);
        done   = (state == DONE);
        rst_ld = (state == LOAD);
        shift  = (state == SHIFT);
        lda2   = '0;
        in_R2  = '0;
        if (state == CORR) begin
            for (int i = 0; i < NDIG; i++) begin
                // A digit of 8 or more after a right shift needs the -3 fix-up.
                lda2[i]          = out_R[4*i+3];
                in_R2[4*i +: 4]  = out_R[4*i +: 4] - 4'd3;
            end
        end
    end

    // Operand latch, iteration counter, result accumulator and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_R1     <= '0;
            cnt       <= '0;
            acc       <= '0;
            bin_out   <= '0;
            ovf       <= 1'b0;
            bad_digit <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                in_R1 <= bcd_in;
                cnt   <= '0;
                acc   <= '0;
                if (nib_bad) begin
                    bad_digit <= 1'b1;
                    bin_out   <= '0;
                    ovf       <= 1'b0;
                end else begin
                    bad_digit <= 1'b0;
                end
            end
            // out_R still holds the pre-shift window here; its LSB is the next result bit.
            if (state_n == SHIFT) begin
                acc <= {out_R[0], acc[ITER-1:1]};
            end
            if (state == CORR) begin
                cnt <= cnt + 1'b1;
                // Whatever remains in the BCD window after all shifts is N / 2**ITER.
                if (state_n == DONE) begin
                    bin_out <= acc;
                    ovf     <= |out_R;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd2bin_ctrl.sv
// Self-checking bench for bcd2bin_ctrl: includes a behavioural rsr4 and checks
// results against the decimal value of the operand.
module tb_bcd2bin_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [19:0] bcd_in;
    logic        busy;
    logic        done;
    logic [15:0] bin_out;
    logic        ovf;
    logic        bad_digit;
    logic        rst_ld;
    logic        shift;
    logic [4:0]  lda2;
    logic [19:0] in_R1;
    logic [19:0] in_R2;
    logic [19:0] out_R;

    int n_tests = 0;
    int n_fail  = 0;

    bcd2bin_ctrl #(.ITER(16), .NDIG(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .bin_out   (bin_out),
        .ovf       (ovf),
        .bad_digit (bad_digit),
        .rst_ld    (rst_ld),
        .shift     (shift),
        .lda2      (lda2),
        .in_R1     (in_R1),
        .in_R2     (in_R2),
        .out_R     (out_R)
    );

    always #5 clk = ~clk;

    // Behavioural rsr4: falling-edge register, load / shift right / per-digit load.
    always @(negedge clk) begin
        if (rst_ld) begin
            out_R <= in_R1;
        end else if (shift) begin
            out_R <= out_R >> 1;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (lda2[i]) out_R[4*i +: 4] <= in_R2[4*i +: 4];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One conversion observed over 40 cycles; optional start re-pulse in cycle restart_at.
    task automatic conv(input logic [19:0] v, input int restart_at);
        int          val;
        bit          bad;
        int          exp_cyc;
        int          done_at;
        int          done_cnt;
        int          busy_err;
        bit          saw_ctl;
        bit          saw_lda;
        logic [15:0] got_bin;
        logic        got_ovf;
        logic        got_bad;
        logic [19:0] got_r;
        logic [15:0] exp_bin;
        logic [19:0] exp_r;

        val = 0;
        bad = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
            val = val * 10 + int'(v[4*i +: 4]);
        end
        exp_cyc = bad ? 1 : 34;
        exp_bin = bad ? 16'h0 : 16'(val % 65536);
        exp_r   = 20'(val / 65536);

        @(posedge clk); #1;
        bcd_in = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        done_at  = -1;
        done_cnt = 0;
        busy_err = 0;
        saw_ctl  = 1'b0;
        saw_lda  = 1'b0;
        got_bin  = '0;
        got_ovf  = 1'b0;
        got_bad  = 1'b0;
        got_r    = '0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (c == restart_at) begin
                start  = 1'b1;
                bcd_in = 20'h99999;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c;
                    got_bin = bin_out;
                    got_ovf = ovf;
                    got_bad = bad_digit;
                    got_r   = out_R;
                end
            end
            if (busy !== (!bad && c <= 33)) busy_err++;
            if (rst_ld || shift) saw_ctl = 1'b1;
            if (lda2 != 5'd0) saw_lda = 1'b1;
        end
        start = 1'b0;

        check($sformatf("done_cycle[%05h]", v), done_at, exp_cyc);
        check($sformatf("done_count[%05h]", v), done_cnt, 1);
        check($sformatf("busy_window[%05h]", v), busy_err, 0);
        check($sformatf("bin_out[%05h]", v), got_bin, exp_bin);
        check($sformatf("ovf[%05h]", v), got_ovf, (!bad && val > 65535));
        check($sformatf("bad_digit[%05h]", v), got_bad, bad);
        check($sformatf("bin_hold[%05h]", v), bin_out, exp_bin);
        if (bad) begin
            check($sformatf("no_ld_shift[%05h]", v), saw_ctl, 0);
        end else begin
            check($sformatf("out_R_done[%05h]", v), got_r, exp_r);
        end
        if (v == 20'h0) check("lda2_quiet[00000]", saw_lda, 0);
    endtask

    initial begin
        logic [19:0] v;
        int          done_seen;

        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        #3;
        check("rst_ctrl", {busy, done, rst_ld, shift, lda2, ovf, bad_digit}, 0);
        check("rst_bin", bin_out, 0);
        check("rst_in_R", {in_R1, in_R2}, 0);
        #9 rst_n = 1'b1;

        conv(20'h12345, 0);
        conv(20'h65535, 0);
        conv(20'h00000, 0);
        conv(20'h99999, 0);
        conv(20'h1A000, 0);
        conv(20'h00100, 10);

        // Randomized valid operands.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 5; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
            conv(v, 0);
        end
        // Randomized operands with one illegal nibble.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
            v[4*$urandom_range(0, 4) +: 4] = 4'($urandom_range(10, 15));
            conv(v, 0);
        end

        // Abort mid-conversion with reset, then convert again.
        @(posedge clk); #1;
        bcd_in = 20'h54321;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ctrl", {busy, done, rst_ld, shift, lda2, ovf, bad_digit}, 0);
        check("abort_bin", bin_out, 0);
        check("abort_in_R", {in_R1, in_R2}, 0);
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        conv(20'h00042, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
